// File: rtl/spm_seq_ctrl_if.sv
// Operand/product handshake bundle for spm_seq_ctrl.
// master = bus side (offers operands, takes products), slave = sequencer.
interface spm_seq_ctrl_if #(
  parameter int N = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_a;
  logic [N-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] out_prod;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_prod
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_prod
  );
endinterface

// File: rtl/spm_seq_ctrl.sv
// Sequencer for a serial-parallel multiplier: latches operands, serialises the multiplier
// LSB-first, collects the 2N-bit product. Define SPM_CTRL_SIGNED_EN for two's-complement operands.
module spm_seq_ctrl #(
  parameter int N     = 8,
  parameter int P_LAT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  spm_seq_ctrl_if.slave bus,
  output logic         busy,
  output logic         spm_clr,
  output logic [N-1:0] spm_x,
  output logic         spm_y,
  input  logic         spm_p,
  output logic [1:0]   dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int RUN_LEN = 2 * N + P_LAT;
  localparam int CW      = $clog2(RUN_LEN + 1);
  localparam logic [CW-1:0] LAST_C = CW'(RUN_LEN - 1);
  localparam logic [CW-1:0] N_C    = CW'(N);

  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic [2*N-1:0] prod;
  logic [N-1:0]   b_shift;
  logic           ext_bit;
  logic           shift_en;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // Input side is ready only in IDLE; output side is valid only in DONE and holds
  // out_prod stable until taken. flush overrides both.
  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.out_prod  = prod;
  assign busy          = (state == S_CLEAR) || (state == S_RUN);
  assign spm_clr       = (state != S_RUN);
  assign spm_x         = a_q;
  assign dbg_state     = state;

  assign b_shift = b_q >> cnt;

`ifdef SPM_CTRL_SIGNED_EN
  assign ext_bit = b_q[N-1];
`else
  assign ext_bit = 1'b0;
`endif

  always_comb begin
    spm_y = 1'b0;
    if (state == S_RUN) begin
      spm_y = (cnt < N_C) ? b_shift[0] : ext_bit;
    end
  end

  // Product bits only start arriving P_LAT cycles into RUN.
  generate
    if (P_LAT == 0) begin : g_no_lat
      assign shift_en = 1'b1;
    end else begin : g_lat
      assign shift_en = (cnt >= CW'(P_LAT));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      prod  <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.in_a;
            b_q   <= bus.in_b;
            state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          cnt   <= '0;
          prod  <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          if (shift_en) begin
            prod <= {spm_p, prod[2*N-1:1]};
          end
          if (cnt == LAST_C) begin
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
